parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, 4, number of parking slots; minimum 1.
REQ-002 Parameter PW_WIDTH, 4, password width in bits.
REQ-003 Parameter PASSWORD, 4'b0101, accepted password; width PW_WIDTH.
REQ-004 Parameter MAX_TRIES, 3, consecutive wrong entries that trigger lockout.
REQ-005 Parameter GATE_TIMEOUT, 16, cycles the gate stays open without a car passing.
REQ-006 Parameter LOCKOUT_CYCLES, 32, lockout duration in cycles.
REQ-007 Port: clk, in, 1, single clock; all state changes on its rising edge.
REQ-008 Port: reset_n, in, 1, reset; asynchronous and active-low.
REQ-009 Port: sensor_entrance, in, 1, car present at the entry gate.
REQ-010 Port: sensor_out, in, 1, car detected past the entry gate.
REQ-011 Port: car_exit, in, 1, single-cycle pulse for each car leaving through the exit lane.
REQ-012 Port: password, in, PW_WIDTH, keypad value; sampled only when password_valid=1.
REQ-013 Port: password_valid, in, 1, single-cycle strobe for a submitted password.
REQ-014 Port: gate_state, out, 1, 1 = gate open.
REQ-015 Port: led_state, out, 3, 000 off / 001 yellow / 010 red / 100 green.
REQ-016 Port: occupancy, out, $clog2(CAPACITY+1), number of occupied slots.
REQ-017 Port: full, out, 1, 1 when occupancy == CAPACITY.
REQ-018 Port: alarm, out, 1, 1 while in LOCKOUT.

Function
REQ-019 States: IDLE, WAIT_PASSWORD, RIGHT_PASSWORD, WRONG_PASSWORD, STOP, LOCKOUT.
REQ-020 All outputs registered; outputs reflect the state entered on the same edge, so each response is one cycle after the input.
REQ-021 IDLE: gate 0; led 000, or 010 while sensor_entrance=1 and full=1; sensor_entrance=1 and full=0 -> WAIT_PASSWORD.
REQ-022 WAIT_PASSWORD: gate 0, led 001.
  - password_valid with a match -> RIGHT_PASSWORD.
  - password_valid with a mismatch -> increment tries, then go to WRONG_PASSWORD, or to LOCKOUT when tries reaches MAX_TRIES.
  - sensor_entrance=0 with no strobe -> IDLE.
REQ-023 WRONG_PASSWORD: gate 0, led 010; password_valid transitions as in WAIT_PASSWORD; sensor_entrance=0 -> IDLE.
REQ-024 RIGHT_PASSWORD: gate 1, led 100; clear tries; start the timeout counter at 0 on entry.
  - sensor_entrance=1 and sensor_out=1 (tailgate) -> STOP.
  - sensor_out=1 and sensor_entrance=0 -> occupancy+1, then IDLE.
  - Counter reaches GATE_TIMEOUT-1 with no sensor_out -> IDLE; occupancy unchanged.
REQ-025 STOP: gate 0, led 010; password_valid with a match -> RIGHT_PASSWORD with the timer restarted; a mismatch is ignored.
REQ-026 LOCKOUT: gate 0, led 010, alarm 1.
  - All password_valid strobes are ignored.
  - After LOCKOUT_CYCLES cycles -> IDLE with tries cleared.
REQ-027 tries counter clears on entry to IDLE from RIGHT_PASSWORD or LOCKOUT; it does not clear when a car simply walks away, so retries accumulate per session.
REQ-028 Occupancy arithmetic:
  - car_exit and a pass-through in the same cycle -> occupancy unchanged.
  - Increment saturates at CAPACITY.
  - car_exit at 0 is ignored.
REQ-029 car_exit is honoured in every state, including LOCKOUT.
REQ-030 password_valid in IDLE, RIGHT_PASSWORD or LOCKOUT has no effect.

Reset
REQ-031 reset_n=0 immediately forces: state IDLE, gate_state 0, led_state 000, occupancy 0, full 0, alarm 0, all counters 0.
REQ-032 Assertion mid-operation, including with the gate open, aborts without counting a car; operation resumes on the first clk edge after release.

Configuration
REQ-033 With macro PARKING_LOCKOUT_EN defined: LOCKOUT, the tries counter and alarm exist as specified.
REQ-034 With PARKING_LOCKOUT_EN undefined:
  - LOCKOUT, tries and the lockout timer are not built.
  - A mismatch always goes to WRONG_PASSWORD, with unlimited retries.
  - alarm is tied to 0.

Verification
REQ-035 Entry: sensor_entrance=1, password 0101 with valid, sensor_out=1 with sensor_entrance=0 -> led 001 -> 100 with gate 1 -> IDLE, occupancy 0->1.
REQ-036 Full: 4 entries with CAPACITY=4 -> full=1; next sensor_entrance -> stays IDLE with led 010; one car_exit pulse -> full=0, occupancy 3.
REQ-037 Lockout (macro defined): three wrong passwords (0000) -> alarm=1 for 32 cycles; 0101 ignored during lockout; then IDLE with alarm 0.
REQ-038 Timeout and tailgate:
  - Gate open with no sensor_out for 16 cycles -> gate 0, occupancy unchanged.
  - Both sensors high -> STOP; 0101 reopens the gate.
REQ-039 Simultaneous and reset: car_exit plus pass-through in one cycle at occupancy 2 -> stays 2; reset_n low while the gate is open -> gate 0, occupancy 0 asynchronously.

Source files
------------

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: sensor, keypad and status signals of the car park gate.
// master drives sensors/keypad, slave is the gate controller.
interface parking_gate_ctrl_if #(
  parameter int CAPACITY = 4,
  parameter int PW_WIDTH = 4
);
  localparam int OCC_W = $clog2(CAPACITY + 1);

  logic                sensor_entrance;
  logic                sensor_out;
  logic                car_exit;
  logic [PW_WIDTH-1:0] password;
  logic                password_valid;
  logic                gate_state;
  logic [2:0]          led_state;
  logic [OCC_W-1:0]    occupancy;
  logic                full;
  logic                alarm;

  modport master (
    output sensor_entrance, sensor_out, car_exit,
    output password, password_valid,
    input  gate_state, led_state, occupancy, full, alarm
  );

  modport slave (
    input  sensor_entrance, sensor_out, car_exit,
    input  password, password_valid,
    output gate_state, led_state, occupancy, full, alarm
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: password-gated car park entry with occupancy count.
// Define PARKING_LOCKOUT_EN to build the wrong-password lockout and alarm.
module parking_gate_ctrl #(
  parameter int                  CAPACITY       = 4,
  parameter int                  PW_WIDTH       = 4,
  parameter logic [PW_WIDTH-1:0] PASSWORD       = 4'b0101,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  GATE_TIMEOUT   = 16,
  parameter int                  LOCKOUT_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  parking_gate_ctrl_if.slave bus
);
  localparam int OCC_W = $clog2(CAPACITY + 1);
`ifdef PARKING_LOCKOUT_EN
  localparam int TMR_MAX = (LOCKOUT_CYCLES > GATE_TIMEOUT) ?
                           LOCKOUT_CYCLES : GATE_TIMEOUT;
  localparam int TR_W = $clog2(MAX_TRIES + 1);
`else
  localparam int TMR_MAX = GATE_TIMEOUT;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RIGHT,
    S_WRONG,
    S_STOP
`ifdef PARKING_LOCKOUT_EN
    , S_LOCK
`endif
  } state_t;

  state_t             r_state, w_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic [OCC_W-1:0]   r_occ, w_occ_nxt;
  logic               r_full, r_gate;
  logic [2:0]         r_led, w_led;
  logic               w_match, w_miss, w_pass;
  logic               w_unused_cfg;

`ifdef PARKING_LOCKOUT_EN
  logic [TR_W-1:0]    r_tries, w_tries_nxt;
  logic               r_alarm;
`endif

  assign w_match = bus.password_valid && (bus.password == PASSWORD);
  assign w_miss  = bus.password_valid && (bus.password != PASSWORD);
  assign w_unused_cfg = (MAX_TRIES + LOCKOUT_CYCLES) > 0;

  always_comb begin
    w_nxt     = r_state;
    w_tmr_nxt = r_tmr;
    w_pass    = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    w_tries_nxt = r_tries;
`endif
    unique case (r_state)
      S_IDLE:
        if (bus.sensor_entrance && !r_full) w_nxt = S_WAIT;
      S_WAIT, S_WRONG:
        if (w_match) begin
          w_nxt     = S_RIGHT;
          w_tmr_nxt = '0;
        end else if (w_miss) begin
`ifdef PARKING_LOCKOUT_EN
          w_tries_nxt = r_tries + 1'b1;
          if (w_tries_nxt == TR_W'(MAX_TRIES)) begin
            w_nxt     = S_LOCK;
            w_tmr_nxt = '0;
          end else begin
            w_nxt = S_WRONG;
          end
`else
          w_nxt = S_WRONG;
`endif
        end else if (!bus.sensor_entrance) begin
          w_nxt = S_IDLE;
        end
      S_RIGHT:
        if (bus.sensor_entrance && bus.sensor_out) begin
          w_nxt = S_STOP;
        end else if (bus.sensor_out) begin
          w_nxt  = S_IDLE;
          w_pass = 1'b1;
        end else if (r_tmr == TMR_W'(GATE_TIMEOUT - 1)) begin
          w_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      S_STOP:
        if (w_match) begin
          w_nxt     = S_RIGHT;
          w_tmr_nxt = '0;
        end
`ifdef PARKING_LOCKOUT_EN
      S_LOCK:
        if (r_tmr == TMR_W'(LOCKOUT_CYCLES - 1)) w_nxt = S_IDLE;
        else w_tmr_nxt = r_tmr + 1'b1;
`endif
      default: w_nxt = S_IDLE;
    endcase
`ifdef PARKING_LOCKOUT_EN
    // walking away from the keypad keeps the retry count
    if (w_nxt == S_RIGHT ||
        (w_nxt == S_IDLE &&
         (r_state == S_RIGHT || r_state == S_LOCK)))
      w_tries_nxt = '0;
`endif
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_pass && bus.car_exit)
      w_occ_nxt = r_occ;
    else if (w_pass && r_occ != OCC_W'(CAPACITY))
      w_occ_nxt = r_occ + 1'b1;
    else if (!w_pass && bus.car_exit && r_occ != '0)
      w_occ_nxt = r_occ - 1'b1;
  end

  always_comb begin
    w_led = 3'b010;
    unique case (w_nxt)
      S_IDLE:  w_led = (bus.sensor_entrance && r_full) ? 3'b010 : 3'b000;
      S_WAIT:  w_led = 3'b001;
      S_RIGHT: w_led = 3'b100;
      default: w_led = 3'b010;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_occ   <= '0;
      r_full  <= 1'b0;
      r_gate  <= 1'b0;
      r_led   <= 3'b000;
    end else begin
      r_state <= w_nxt;
      r_tmr   <= w_tmr_nxt;
      r_occ   <= w_occ_nxt;
      r_full  <= (w_occ_nxt == OCC_W'(CAPACITY));
      r_gate  <= (w_nxt == S_RIGHT);
      r_led   <= w_led;
    end
  end

`ifdef PARKING_LOCKOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tries <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_tries <= w_tries_nxt;
      r_alarm <= (w_nxt == S_LOCK);
    end
  end

  assign bus.alarm = r_alarm;
`else
  assign bus.alarm = 1'b0;
`endif

  assign bus.gate_state = r_gate;
  assign bus.led_state  = r_led;
  assign bus.occupancy  = r_occ;
  assign bus.full       = r_full;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table, directed corner sequences and random
// stimulus against a behavioural model of the car park gate.
module tb_parking_gate_ctrl;
  localparam int CAP = 4;
  localparam int PWW = 4;
  localparam int MAXT = 3;
  localparam int GTO = 16;
  localparam int LKC = 32;
  localparam logic [3:0] PW_OK  = 4'b0101;
  localparam logic [3:0] PW_BAD = 4'b0000;
`ifdef PARKING_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  parking_gate_ctrl_if #(.CAPACITY(CAP), .PW_WIDTH(PWW)) bus ();

  parking_gate_ctrl #(
    .CAPACITY(CAP), .PW_WIDTH(PWW), .PASSWORD(PW_OK),
    .MAX_TRIES(MAXT), .GATE_TIMEOUT(GTO), .LOCKOUT_CYCLES(LKC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef enum int {MI, MW, MR, MWR, MS, ML} mmode_t;
  mmode_t m_mode = MI;
  int m_tries = 0, m_age = 0, m_rem = 0, m_occ = 0;
  logic [2:0] m_led = 3'b000;

  typedef struct {
    bit e, o, x, pv;
    logic [3:0] pw;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[$];

  function automatic logic [8:0] pk(bit g, logic [2:0] led, int occ,
                                    bit f, bit a);
    return {g, led, 3'(occ), f, a};
  endfunction

  function automatic logic [8:0] dut_out();
    return {bus.gate_state, bus.led_state, bus.occupancy, bus.full, bus.alarm};
  endfunction

  function automatic logic [8:0] model_out();
    return pk(m_mode == MR, m_led, m_occ, m_occ == CAP, m_mode == ML);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MI; m_tries = 0; m_age = 0; m_rem = 0; m_occ = 0;
    m_led = 3'b000;
  endtask

  // One clock edge of the gate rules, applied to the pre-edge situation.
  task automatic model_step(input bit e, o, x, pv, input logic [3:0] pw);
    bit match = pv && (pw == PW_OK);
    bit miss  = pv && (pw != PW_OK);
    bit was_full = (m_occ == CAP);
    bit pass = 1'b0;
    case (m_mode)
      MI: if (e && !was_full) m_mode = MW;
      MW, MWR:
        if (match) begin
          m_mode = MR; m_tries = 0; m_age = 0;
        end else if (miss) begin
          m_tries++;
          if (LOCK_EN && m_tries >= MAXT) begin
            m_mode = ML; m_rem = LKC;
          end else m_mode = MWR;
        end else if (!e) m_mode = MI;
      MR:
        if (e && o) m_mode = MS;
        else if (o) begin
          pass = 1'b1; m_mode = MI; m_tries = 0;
        end else begin
          m_age++;
          if (m_age == GTO) begin m_mode = MI; m_tries = 0; end
        end
      MS: if (match) begin m_mode = MR; m_age = 0; m_tries = 0; end
      ML: begin
        m_rem--;
        if (m_rem == 0) begin m_mode = MI; m_tries = 0; end
      end
      default: m_mode = MI;
    endcase
    if (pass && x) m_occ = m_occ;
    else if (pass) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;
    else if (x && m_occ > 0) m_occ--;
    case (m_mode)
      MI: m_led = (e && was_full) ? 3'b010 : 3'b000;
      MW: m_led = 3'b001;
      MR: m_led = 3'b100;
      default: m_led = 3'b010;
    endcase
  endtask

  task automatic cyc(input bit e, o, x, pv, input logic [3:0] pw);
    bus.sensor_entrance = e;
    bus.sensor_out      = o;
    bus.car_exit        = x;
    bus.password_valid  = pv;
    bus.password        = pw;
    @(posedge clk);
    #1;
    model_step(e, o, x, pv, pw);
    chk("model", int'(dut_out()), int'(model_out()));
  endtask

  task automatic enter_car();
    cyc(1, 0, 0, 0, PW_BAD);
    cyc(1, 0, 0, 1, PW_OK);
    cyc(0, 1, 0, 0, PW_BAD);
  endtask

  task automatic do_reset();
    bus.sensor_entrance = 0; bus.sensor_out = 0; bus.car_exit = 0;
    bus.password_valid = 0; bus.password = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_state", int'(dut_out()), int'(pk(0, 3'b000, 0, 0, 0)));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    tv.push_back('{1, 0, 0, 0, PW_BAD, pk(0, 3'b001, 0, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_OK,  pk(1, 3'b100, 0, 0, 0)});
    tv.push_back('{0, 1, 0, 0, PW_BAD, pk(0, 3'b000, 1, 0, 0)});
    tv.push_back('{1, 0, 0, 0, PW_BAD, pk(0, 3'b001, 1, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_BAD, pk(0, 3'b010, 1, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_OK,  pk(1, 3'b100, 1, 0, 0)});
    tv.push_back('{0, 1, 0, 0, PW_BAD, pk(0, 3'b000, 2, 0, 0)});
    tv.push_back('{1, 0, 0, 0, PW_BAD, pk(0, 3'b001, 2, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_OK,  pk(1, 3'b100, 2, 0, 0)});
    tv.push_back('{1, 1, 0, 0, PW_BAD, pk(0, 3'b010, 2, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_BAD, pk(0, 3'b010, 2, 0, 0)});
    tv.push_back('{1, 0, 0, 1, PW_OK,  pk(1, 3'b100, 2, 0, 0)});
    tv.push_back('{0, 1, 1, 0, PW_BAD, pk(0, 3'b000, 2, 0, 0)});
    tv.push_back('{0, 0, 1, 0, PW_BAD, pk(0, 3'b000, 1, 0, 0)});
    tv.push_back('{0, 0, 1, 0, PW_BAD, pk(0, 3'b000, 0, 0, 0)});
    tv.push_back('{0, 0, 1, 0, PW_BAD, pk(0, 3'b000, 0, 0, 0)});
    foreach (tv[i]) begin
      cyc(tv[i].e, tv[i].o, tv[i].x, tv[i].pv, tv[i].pw);
      chk($sformatf("vec%0d", i), int'(dut_out()), int'(tv[i].exp));
    end

    // gate left open with nobody passing
    cyc(1, 0, 0, 0, PW_BAD);
    cyc(1, 0, 0, 1, PW_OK);
    for (int i = 1; i <= GTO; i++) begin
      cyc(0, 0, 0, 0, PW_BAD);
      chk($sformatf("timeout_gate%0d", i), int'(bus.gate_state),
          (i < GTO) ? 1 : 0);
    end
    chk("timeout_occ", int'(bus.occupancy), 0);

    // fill up, get refused, then one car leaves
    for (int i = 0; i < CAP; i++) enter_car();
    chk("full_occ", int'(bus.occupancy), CAP);
    chk("full_flag", int'(bus.full), 1);
    cyc(1, 0, 0, 0, PW_BAD);
    chk("full_refuse1", int'(dut_out()), int'(pk(0, 3'b010, CAP, 1, 0)));
    cyc(1, 0, 0, 1, PW_OK);
    chk("full_refuse2", int'(dut_out()), int'(pk(0, 3'b010, CAP, 1, 0)));
    cyc(0, 0, 1, 0, PW_BAD);
    chk("full_exit", int'(dut_out()), int'(pk(0, 3'b000, CAP - 1, 0, 0)));

    // asynchronous reset while the gate is open
    cyc(1, 0, 0, 0, PW_BAD);
    cyc(1, 0, 0, 1, PW_OK);
    chk("pre_reset_gate", int'(bus.gate_state), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset", int'(dut_out()), int'(pk(0, 3'b000, 0, 0, 0)));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc(0, 1, 0, 0, PW_BAD);
    chk("post_reset_idle", int'(dut_out()), int'(pk(0, 3'b000, 0, 0, 0)));

    cyc(1, 0, 0, 0, PW_BAD);
`ifdef PARKING_LOCKOUT_EN
    cyc(1, 0, 0, 1, PW_BAD);
    cyc(1, 0, 0, 1, PW_BAD);
    cyc(1, 0, 0, 1, PW_BAD);
    chk("lock_enter", int'(dut_out()), int'(pk(0, 3'b010, 0, 0, 1)));
    for (int i = 1; i <= LKC; i++) begin
      cyc(0, 0, 0, (i % 3) == 0, PW_OK);
      chk($sformatf("lock_alarm%0d", i), int'(bus.alarm),
          (i < LKC) ? 1 : 0);
    end
    chk("lock_exit", int'(dut_out()), int'(pk(0, 3'b000, 0, 0, 0)));
`else
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 1, PW_BAD);
      chk($sformatf("retry%0d", i), int'(dut_out()),
          int'(pk(0, 3'b010, 0, 0, 0)));
    end
    cyc(1, 0, 0, 1, PW_OK);
    chk("retry_ok", int'(dut_out()), int'(pk(1, 3'b100, 0, 0, 0)));
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 1, $urandom_range(0, 9) < 3,
          ($urandom_range(0, 1) == 1) ? PW_OK : 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
